// File: rtl/time_set_entry.sv
// Keypad time-setting front end: gathers HH:MM BCD digits from a key stream,
// validates them by position and presents them to the clock for one cycle on commit.
module time_set_entry #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [3:0]  hour1,
    output logic [3:0]  hour0,
    output logic [3:0]  minute1,
    output logic [3:0]  minute0,
    output logic        commit,
    output logic        edit_active,
    output logic [1:0]  edit_pos,
    output logic [15:0] disp_digits,
    output logic        key_err,
    output logic        abort
);

    localparam logic [3:0]  KEY_CANCEL  = 4'hB;
    localparam logic [3:0]  KEY_CONFIRM = 4'hC;
    localparam logic [3:0]  KEY_START   = 4'hD;
    localparam logic [15:0] NO_SET      = 16'hAAAA;

    typedef enum logic [2:0] {
        IDLE, S_H1, S_H0, S_M1, S_M0, S_CONF, S_COMMIT
    } state_t;

    state_t      state, state_nx;
    logic [15:0] disp_nx;
    logic [15:0] set_nx;
    logic        commit_nx, err_nx, abort_nx;
    logic [31:0] cnt, cnt_nx;
    logic [3:0]  slot_max;
    logic        digit_ok;
    logic        timeout_hit;

    // Largest digit each slot accepts; H0 is limited to 3 once the tens digit is 2.
    always_comb begin
        slot_max = 4'd9;
        case (state)
            S_H1:    slot_max = 4'd2;
            S_H0:    slot_max = (disp_digits[15:12] == 4'd2) ? 4'd3 : 4'd9;
            S_M1:    slot_max = 4'd5;
            default: slot_max = 4'd9;
        endcase
    end

    assign digit_ok    = (key_code <= 4'd9) && (key_code <= slot_max);
    assign timeout_hit = (cnt == TIMEOUT_CYCLES - 32'd2);

    always_comb begin
        state_nx  = state;
        disp_nx   = disp_digits;
        set_nx    = NO_SET;
        commit_nx = 1'b0;
        err_nx    = 1'b0;
        abort_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid && key_code == KEY_START)
                    state_nx = S_H1;
            end
            S_COMMIT: state_nx = IDLE;
            default: begin
                if (key_valid) begin
                    if (key_code == KEY_CANCEL) begin
                        state_nx = IDLE;
                        abort_nx = 1'b1;
                    end else if (key_code == KEY_CONFIRM) begin
                        if (state == S_M1) begin
                            state_nx  = S_COMMIT;
                            set_nx    = {disp_digits[15:8], 8'hAA};
                            commit_nx = 1'b1;
                        end else if (state == S_CONF) begin
                            state_nx  = S_COMMIT;
                            set_nx    = disp_digits;
                            commit_nx = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (digit_ok && state != S_CONF) begin
                        case (state)
                            S_H1: begin disp_nx[15:12] = key_code; state_nx = S_H0;   end
                            S_H0: begin disp_nx[11:8]  = key_code; state_nx = S_M1;   end
                            S_M1: begin disp_nx[7:4]   = key_code; state_nx = S_M0;   end
                            default: begin disp_nx[3:0] = key_code; state_nx = S_CONF; end
                        endcase
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                    abort_nx = 1'b1;
                end
            end
        endcase
        if (state_nx == IDLE)
            disp_nx = NO_SET;
        cnt_nx = (state_nx == IDLE || key_valid) ? 32'd0 : cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            disp_digits <= NO_SET;
            {hour1, hour0, minute1, minute0} <= NO_SET;
            commit      <= 1'b0;
            key_err     <= 1'b0;
            abort       <= 1'b0;
            cnt         <= 32'd0;
        end else begin
            state       <= state_nx;
            disp_digits <= disp_nx;
            {hour1, hour0, minute1, minute0} <= set_nx;
            commit      <= commit_nx;
            key_err     <= err_nx;
            abort       <= abort_nx;
            cnt         <= cnt_nx;
        end
    end

    assign edit_active = (state != IDLE);

    always_comb begin
        edit_pos = 2'd0;
        case (state)
            S_H0:    edit_pos = 2'd1;
            S_M1:    edit_pos = 2'd2;
            S_M0:    edit_pos = 2'd3;
            default: edit_pos = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_time_set_entry.sv
// Bench for time_set_entry: directed key sequences then random key streams,
// every output compared each cycle against a digit-list reference model.
module tb_time_set_entry;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [3:0]  hour1, hour0, minute1, minute0;
    logic        commit, edit_active, key_err, abort;
    logic [1:0]  edit_pos;
    logic [15:0] disp_digits;

    int errors = 0;
    int checks = 0;

    // reference model: an entry is a list of digits typed so far
    bit m_active, m_pending;
    int m_pos, m_idle;
    int m_dig[4];
    int exp_set[4];
    bit exp_commit, exp_err, exp_abort;

    time_set_entry #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .hour1(hour1), .hour0(hour0), .minute1(minute1), .minute0(minute0),
        .commit(commit), .edit_active(edit_active), .edit_pos(edit_pos),
        .disp_digits(disp_digits), .key_err(key_err), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic go_idle();
        m_active = 0; m_pending = 0; m_pos = 0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 10;
    endtask

    function automatic bit legal(input int pos, input int d);
        case (pos)
            0: return d <= 2;
            1: return d <= ((m_dig[0] == 2) ? 3 : 9);
            2: return d <= 5;
            3: return d <= 9;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit v, input int c, input bit r);
        exp_commit = 0; exp_err = 0; exp_abort = 0;
        for (int i = 0; i < 4; i++) exp_set[i] = 10;
        if (!r) go_idle();
        else if (m_pending) go_idle();
        else if (!m_active) begin
            if (v && c == 13) begin
                go_idle();
                m_active = 1;
            end
        end else if (v) begin
            m_idle = 0;
            if (c <= 9) begin
                if (m_pos < 4 && legal(m_pos, c)) begin
                    m_dig[m_pos] = c;
                    m_pos++;
                end else exp_err = 1;
            end else if (c == 11) begin
                go_idle();
                exp_abort = 1;
            end else if (c == 12) begin
                if (m_pos == 2 || m_pos == 4) begin
                    exp_commit = 1;
                    for (int i = 0; i < 4; i++) exp_set[i] = (i < m_pos) ? m_dig[i] : 10;
                    m_active = 0;
                    m_pending = 1;
                end else exp_err = 1;
            end else exp_err = 1;
        end else begin
            m_idle++;
            if (m_idle == TO - 1) begin
                go_idle();
                exp_abort = 1;
            end
        end
    endtask

    task automatic compare_all();
        int disp;
        disp = 16'hAAAA;
        if (m_active || m_pending)
            disp = (m_dig[0] << 12) | (m_dig[1] << 8) | (m_dig[2] << 4) | m_dig[3];
        check_val("hour1", hour1, exp_set[0]);
        check_val("hour0", hour0, exp_set[1]);
        check_val("minute1", minute1, exp_set[2]);
        check_val("minute0", minute0, exp_set[3]);
        check_val("commit", commit, exp_commit);
        check_val("key_err", key_err, exp_err);
        check_val("abort", abort, exp_abort);
        check_val("edit_active", edit_active, m_active || m_pending);
        check_val("edit_pos", edit_pos, (m_active && m_pos < 4) ? m_pos : 0);
        check_val("disp_digits", disp_digits, disp);
    endtask

    task automatic cycle(input bit v, input int c, input bit r);
        key_valid = v;
        key_code  = 4'(c);
        rst       = r;
        @(posedge clk);
        model_step(v, c, r);
        #1;
        compare_all();
    endtask

    task automatic key(input int c);
        cycle(1, c, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    initial begin
        go_idle();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        // full entry and commit
        key(13); key(2); key(3); key(5); key(9); key(12); idle(2);
        // hours-only commit after a rejected H0
        key(13); key(2); key(4); key(1); key(12); idle(2);
        // rejected M1 then cancel
        key(13); key(0); key(7); key(6); key(11); idle(2);
        // timeout
        key(13); key(1); idle(9);
        // key arriving in the timeout cycle wins
        key(13); key(1); idle(6); key(2); idle(3); key(11);
        // reset mid-entry
        key(13); key(1); key(2); cycle(0, 0, 0); cycle(0, 0, 0); idle(1);
        // keys ignored in IDLE, digit in S_CONF rejected
        key(5); key(12); key(11);
        key(13); key(1); key(2); key(3); key(4); key(7); key(11); idle(2);

        // random key streams, alternating dense and sparse phases
        for (int n = 0; n < 4000; n++) begin
            int dens, sel, c;
            bit v, r;
            dens = ((n / 200) % 2 == 0) ? 50 : 8;
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 99) < dens);
            sel = $urandom_range(0, 19);
            if (sel < 2) c = 13;
            else if (sel < 4) c = 12;
            else if (sel < 5) c = 11;
            else if (sel < 6) c = $urandom_range(0, 15);
            else c = $urandom_range(0, 5);
            cycle(v, c, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
